// File: rtl/io_input_conditioner.sv
// Synchronizes and debounces raw pushbuttons (active-low) and slide switches,
// producing debounced levels, one-cycle press pulses and sticky press flags.
module io_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] buttons_n,
  input  logic [9:0] switches_raw,
  input  logic [3:0] evt_clr,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_event,
  output logic       evt_any,
  output logic [9:0] sw_stable
);

  localparam int NCH = 14;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]     btn_sync_p1, btn_sync_p2;
  logic [9:0]     sw_sync_p1, sw_sync_p2;
  logic [NCH-1:0] sample;
  logic [NCH-1:0] stable, stable_nxt;
  logic [CNT_W-1:0] cnt     [NCH];
  logic [CNT_W-1:0] cnt_nxt [NCH];
  logic [3:0]     rise;

  // Buttons are inverted only after the synchronizer so both flops stay logic-free.
  assign sample = {sw_sync_p2, ~btn_sync_p2};

  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < NCH; i++) begin
      cnt_nxt[i] = '0;
      if (sample[i] != stable[i]) begin
        if (cnt[i] == CNT_MAX) stable_nxt[i] = sample[i];
        else                   cnt_nxt[i]    = cnt[i] + CNT_W'(1);
      end
    end
  end

  assign rise = stable_nxt[3:0] & ~stable[3:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync_p1 <= 4'hF;
      btn_sync_p2 <= 4'hF;
      sw_sync_p1  <= '0;
      sw_sync_p2  <= '0;
      stable      <= '0;
      btn_press   <= '0;
      btn_event   <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else begin
      // Stage p1/p2: two-flop synchronizer.
      btn_sync_p1 <= buttons_n;
      btn_sync_p2 <= btn_sync_p1;
      sw_sync_p1  <= switches_raw;
      sw_sync_p2  <= sw_sync_p1;
      // Debounce stage: set beats clear on the event flags.
      stable      <= stable_nxt;
      btn_press   <= rise;
      btn_event   <= rise | (btn_event & ~evt_clr);
      for (int i = 0; i < NCH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign btn_level = stable[3:0];
  assign sw_stable = stable[13:4];
  assign evt_any   = |btn_event;

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
- Input-conditioning stage directly upstream of cpu_environment's `buttons` and `switches` inputs.
- Synchronizes the raw board pushbuttons and slide switches to `clk` and debounces each bit.
- Produces active-high button levels, one-cycle press pulses, and sticky press-event flags that the CPU polls and clears.
- Raw buttons are active-low: 4'b1111 means idle, and 4'b1110 means button 0 is pressed.

Parameters:
- DEBOUNCE_CYCLES, 4, number of consecutive cycles a synchronized bit must differ from its stable value before the stable value updates. Must be ≥1. Large values are for hardware; 4 is for simulation.
- CNT_W, 16, counter width. Requires 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- buttons_n, input, 4, raw pushbuttons, active-low, asynchronous to clk.
- switches_raw, input, 10, raw slide switches, active-high, asynchronous.
- evt_clr, input, 4, per-bit clear of btn_event; sampled on the edge.
- btn_level, output, 4, debounced button state, active-high (1 = pressed).
- btn_press, output, 4, one-cycle pulse on a debounced press (0→1 of btn_level).
- btn_event, output, 4, sticky press flags.
- evt_any, output, 1, OR-reduction of btn_event.
- sw_stable, output, 10, debounced switch state.

Behaviour:
- 14 identical channels: 4 buttons and 10 switches. Button channels invert the raw input after synchronization.
- Per channel: sync1 ← raw; sync2 ← sync1. Two-flop synchronizer, no logic between the flops.
- Per channel: counter cnt and a stable bit. On each edge:
  - If sync2 (inverted for buttons) equals stable: cnt ← 0.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1: stable ← new value, cnt ← 0.
  - Otherwise: cnt ← cnt+1.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles never changes stable. Any return to agreement restarts the count from 0.
- Latency: raw change sampled at edge k appears on btn_level/sw_stable after edge k+1+DEBOUNCE_CYCLES. With the default of 4, that is after edge k+5.
- btn_press[i] is a register. It is set to 1 on the edge where stable[i] goes 0→1 and is 0 on every other edge. No pulse on release.
- btn_event[i] on each edge:
  - Set when btn_press[i] is being set on that edge.
  - Else cleared when evt_clr[i] = 1.
  - Else held.
  - If set and clear coincide, set wins and the flag stays 1.
- evt_any is combinational OR of btn_event.
- Reset values, applied on a clk edge with reset = 1, taking priority over everything:
  - button sync flops = 1 (released); switch sync flops = 0.
  - cnt = 0; btn_level = 0; sw_stable = 0.
  - btn_press = 0; btn_event = 0; evt_any = 0.
- Reset mid-debounce discards the partial count.
- After reset deasserts, a held switch or button reappears with full latency (2 + DEBOUNCE_CYCLES edges). A button held across reset produces a btn_press when it reappears.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Channels are fully independent. Simultaneous presses on several buttons produce simultaneous pulses.

Test Plan:
- Reset/idle: reset = 1 for 2 edges with buttons_n = 4'b1111 and switches_raw = 10'h2A5. Then release reset.
  - During reset, all outputs are 0.
  - sw_stable = 10'h2A5 after the 6th edge following reset release; btn_level stays 0.
- Clean press: set buttons_n = 4'b1110 just before edge k.
  - btn_level = 4'b0001 after edge k+5.
  - btn_press = 4'b0001 for exactly one cycle, then 0.
  - btn_event = 4'b0001 and evt_any = 1 until cleared.
- Glitch rejection: buttons_n = 4'b1101 held for 3 cycles, then 4'b1111.
  - btn_level, btn_press and btn_event remain 0.
  - Repeat with a 4-cycle pulse: btn_level[1] goes to 1.
- Release/clear: after a clean press of button 0, return buttons_n to 4'b1111.
  - btn_level = 0 after 5 edges; no pulse on release.
  - Pulse evt_clr = 4'b0001 for one cycle: btn_event = 0 and evt_any = 0 on the next cycle.
- Set/clear collision: hold evt_clr = 4'b0100 continuously and press button 2.
  - btn_event[2] = 1 for exactly the cycle after the press edge, then 0.
- Reset mid-debounce: buttons_n = 4'b0111 for 3 edges, then reset = 1 for 1 edge, then reset = 0 with the button still held.
  - btn_level[3] rises only 6 edges after reset release, with a single btn_press pulse.
